// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp,
// FSM states and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Must stay in step with the ALU control unit's decode table.
    localparam logic [2:0] ALUOP_NONE = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_LUI  = 3'b011;
    localparam logic [2:0] ALUOP_ADD  = 3'b100;
    localparam logic [2:0] ALUOP_ORI  = 3'b101;
    localparam logic [2:0] ALUOP_ANDI = 3'b110;
    localparam logic [2:0] ALUOP_R    = 3'b111;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_ALUWB_R, S_EXEC_I, S_ALUWB_I, S_BRANCH, S_JUMP, S_JAL
    } state_t;

    typedef struct packed {
        state_t     nxt;
        logic [2:0] alu_op;
        logic       illegal;
        logic       is_store;
        logic       is_bne;
    } dec_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Opcode lookup: the state DECODE dispatches to, plus the I-type ALUOp
// and the store/BNE qualifiers used later in the instruction.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec.nxt      = S_FETCH;
        dec.alu_op   = ALUOP_ADD;
        dec.illegal  = 1'b0;
        dec.is_store = (opcode == OP_SW);
        dec.is_bne   = (opcode == OP_BNE);
        case (opcode)
            OP_RTYPE:      dec.nxt = S_EXEC_R;
            OP_LW, OP_SW:  dec.nxt = S_MEMADR;
            OP_BEQ, OP_BNE: dec.nxt = S_BRANCH;
            OP_J:          dec.nxt = S_JUMP;
            OP_JAL:        dec.nxt = S_JAL;
            OP_ADDI: begin dec.nxt = S_EXEC_I; dec.alu_op = ALUOP_ADD;  end
            OP_ANDI: begin dec.nxt = S_EXEC_I; dec.alu_op = ALUOP_ANDI; end
            OP_ORI:  begin dec.nxt = S_EXEC_I; dec.alu_op = ALUOP_ORI;  end
            OP_LUI:  begin dec.nxt = S_EXEC_I; dec.alu_op = ALUOP_LUI;  end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Outputs are a pure
// decode of state/funct/mem_ready so reset drops every strobe at once.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                PCWriteCondN,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic [2:0]          ALUOp,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [RETIRE_W-1:0] retired
);

    state_t state, next_state;
    dec_t   dec;

    // The branch condition is applied by the datapath PC gate, not here.
    logic unused_zero;
    assign unused_zero = zero;

    mips_ctrl_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            retired <= '0;
        end else begin
            state <= next_state;
            if (instr_done) retired <= retired + RETIRE_W'(1);
        end
    end

    always_comb begin
        next_state   = state;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        PCWriteCondN = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = REGDST_RT;
        MemtoReg     = M2R_ALU;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        PCSrc        = PCSRC_ALU;
        ALUOp        = ALUOP_NONE;
        illegal_op   = 1'b0;
        instr_done   = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                ALUOp   = ALUOP_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH;
                ALUOp      = ALUOP_ADD;
                illegal_op = dec.illegal;
                next_state = dec.nxt;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_R;
                if (funct == FN_JR) begin
                    PCWrite    = 1'b1;
                    PCSrc      = PCSRC_REG;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_ALUWB_R;
                end
            end
            S_ALUWB_R: begin
                RegDst     = REGDST_RD;
                RegWrite   = 1'b1;
                ALUOp      = ALUOP_R;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = dec.alu_op;
                next_state = S_ALUWB_I;
            end
            S_ALUWB_I: begin
                RegWrite   = 1'b1;
                ALUOp      = dec.alu_op;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_ADD;
                next_state = dec.is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEMWB: begin
                MemtoReg   = M2R_MDR;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALUOP_SUB;
                PCSrc        = PCSRC_ALUOUT;
                PCWriteCond  = ~dec.is_bne;
                PCWriteCondN = dec.is_bne;
                instr_done   = 1'b1;
                next_state   = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = PCSRC_JUMP;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSrc      = PCSRC_JUMP;
                RegWrite   = 1'b1;
                RegDst     = REGDST_RA;
                MemtoReg   = M2R_PC;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scenario bench for the multicycle control FSM; retire events are checked
// against a queue of expected latencies and retire counts.
module tb_mips_multicycle_control;

    logic clk, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
    logic RegWrite, ALUSrcA, illegal_op, instr_done;
    logic [2:0] ALUOp;
    logic [31:0] retired;

    logic w_pcw, w_pcc, w_pcn, w_iord, w_mr, w_mw, w_irw, w_rw, w_srca, w_ill, w_done;
    logic [1:0] w_regdst, w_m2r, w_srcb, w_pcsrc;
    logic [2:0] w_aluop;
    logic [3:0] retired_4;

    mips_multicycle_control #(.RETIRE_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCWriteCondN(PCWriteCondN), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .illegal_op(illegal_op),
        .instr_done(instr_done), .retired(retired)
    );

    mips_multicycle_control #(.RETIRE_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(w_pcw), .PCWriteCond(w_pcc),
        .PCWriteCondN(w_pcn), .IorD(w_iord), .MemRead(w_mr),
        .MemWrite(w_mw), .IRWrite(w_irw), .RegDst(w_regdst),
        .MemtoReg(w_m2r), .RegWrite(w_rw), .ALUSrcA(w_srca),
        .ALUSrcB(w_srcb), .PCSrc(w_pcsrc), .ALUOp(w_aluop), .illegal_op(w_ill),
        .instr_done(w_done), .retired(retired_4)
    );

    wire [21:0] all_out = {PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite,
                           IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                           PCSrc, ALUOp, illegal_op, instr_done};
    wire [5:0] strobes = {RegWrite, MemWrite, PCWrite, PCWriteCond, PCWriteCondN, IRWrite};

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] exp_retired;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-instruction observations filled in by run_instr.
    logic [2:0] hist [0:15];
    int n_irw, n_rw;
    logic s_pcw, s_pcc, s_pcn, s_rw, s_mw, s_iord;
    logic [1:0] s_regdst, s_m2r, s_pcsrc;
    logic [2:0] s_aluop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && instr_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire: instr_done=1 at cycle %0d, required no retire", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc - e.start + 1 != e.lat) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, required %0d", cyc - e.start + 1, e.lat);
                end
                checks += 2;
                if (retired !== e.ret) begin
                    errors++;
                    $display("FAIL retired_pre: got %0d, required %0d", retired, e.ret);
                end
                if (retired_4 !== e.ret[3:0]) begin
                    errors++;
                    $display("FAIL retired4_pre: got %0d, required %0d", retired_4, e.ret[3:0]);
                end
            end
        end
    end

    // Starts in a FETCH cycle; stall bit c drops mem_ready in cycle c.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int lat,
                             input logic [15:0] stall);
        exp_t e;
        logic seen;
        opcode = op;
        funct  = fn;
        e.start = cyc;
        e.lat   = lat;
        e.ret   = exp_retired;
        exp_q.push_back(e);
        exp_retired = exp_retired + 32'd1;
        n_irw = 0;
        n_rw  = 0;
        seen  = 1'b0;
        for (int c = 0; c < 16; c++) begin
            mem_ready = ~stall[c];
            #1;
            hist[c] = ALUOp;
            n_irw += int'(IRWrite);
            n_rw  += int'(RegWrite);
            if (instr_done) begin
                seen = 1'b1;
                {s_pcw, s_pcc, s_pcn, s_rw, s_mw, s_iord} =
                    {PCWrite, PCWriteCond, PCWriteCondN, RegWrite, MemWrite, IorD};
                {s_regdst, s_m2r, s_pcsrc, s_aluop} = {RegDst, MemtoReg, PCSrc, ALUOp};
            end
            @(posedge clk);
            #1;
            if (seen) break;
        end
        mem_ready = 1'b1;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: opcode %b never retired, required latency %0d", op, lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
        exp_retired = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (all_out !== 22'd0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", all_out); end
        if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d, required 0", retired); end
        reset = 1'b0;
        #1;
        checks++;
        if (all_out !== 22'd0) begin errors++; $display("FAIL idle_outputs: got %h, required 0", all_out); end
        @(posedge clk);
        #1;
        run_instr(6'b000000, 6'b100000, 4, 16'h0000);
        checks += 5;
        if (hist[2] !== 3'b111) begin errors++; $display("FAIL exec_r_aluop: got %b, required 111", hist[2]); end
        if (s_rw !== 1'b1) begin errors++; $display("FAIL aluwb_r_regwrite: got %b, required 1", s_rw); end
        if (s_regdst !== 2'b01) begin errors++; $display("FAIL aluwb_r_regdst: got %b, required 01", s_regdst); end
        if (s_aluop !== 3'b111) begin errors++; $display("FAIL aluwb_r_aluop: got %b, required 111", s_aluop); end
        if (retired !== 32'd1) begin errors++; $display("FAIL r_retired: got %0d, required 1", retired); end
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'b000000, 8, 16'h0023);
        checks += 4;
        if (n_irw !== 1) begin errors++; $display("FAIL lw_irwrite_count: got %0d, required 1", n_irw); end
        if (s_m2r !== 2'b01) begin errors++; $display("FAIL lw_memtoreg: got %b, required 01", s_m2r); end
        if (s_rw !== 1'b1 || s_regdst !== 2'b00) begin
            errors++; $display("FAIL lw_writeback: got rw=%b regdst=%b, required rw=1 regdst=00", s_rw, s_regdst);
        end
        if (retired !== exp_retired) begin errors++; $display("FAIL lw_retired: got %0d, required %0d", retired, exp_retired); end
    endtask

    task automatic test_branch();
        zero = 1'b1;
        run_instr(6'b000100, 6'b000000, 3, 16'h0000);
        checks += 3;
        if (s_pcc !== 1'b1 || s_pcn !== 1'b0) begin
            errors++; $display("FAIL beq_cond: got cond=%b condn=%b, required 1/0", s_pcc, s_pcn);
        end
        if (s_aluop !== 3'b001) begin errors++; $display("FAIL beq_aluop: got %b, required 001", s_aluop); end
        if (s_pcsrc !== 2'b01) begin errors++; $display("FAIL beq_pcsrc: got %b, required 01", s_pcsrc); end
        run_instr(6'b000101, 6'b000000, 3, 16'h0000);
        checks++;
        if (s_pcn !== 1'b1 || s_pcc !== 1'b0) begin
            errors++; $display("FAIL bne_cond: got condn=%b cond=%b, required 1/0", s_pcn, s_pcc);
        end
        zero = 1'b0;
    endtask

    task automatic test_jr_jal();
        run_instr(6'b000000, 6'b001000, 3, 16'h0000);
        checks += 2;
        if (s_pcsrc !== 2'b11 || s_pcw !== 1'b1) begin
            errors++; $display("FAIL jr_pc: got pcsrc=%b pcwrite=%b, required 11/1", s_pcsrc, s_pcw);
        end
        if (n_rw !== 0) begin errors++; $display("FAIL jr_regwrite: got %0d cycles, required 0", n_rw); end
        run_instr(6'b000011, 6'b000000, 3, 16'h0000);
        checks += 2;
        if (s_regdst !== 2'b10 || s_m2r !== 2'b10) begin
            errors++; $display("FAIL jal_sel: got regdst=%b memtoreg=%b, required 10/10", s_regdst, s_m2r);
        end
        if (s_rw !== 1'b1 || s_pcw !== 1'b1) begin
            errors++; $display("FAIL jal_strobes: got rw=%b pcw=%b, required 1/1", s_rw, s_pcw);
        end
    endtask

    task automatic test_itype();
        run_instr(6'b001101, 6'b000000, 4, 16'h0000);
        checks += 2;
        if (hist[2] !== 3'b101 || hist[3] !== 3'b101) begin
            errors++; $display("FAIL ori_aluop: got %b/%b, required 101/101", hist[2], hist[3]);
        end
        if (s_rw !== 1'b1 || s_regdst !== 2'b00) begin
            errors++; $display("FAIL ori_wb: got rw=%b regdst=%b, required 1/00", s_rw, s_regdst);
        end
        run_instr(6'b001100, 6'b000000, 4, 16'h0000);
        checks++;
        if (hist[2] !== 3'b110) begin errors++; $display("FAIL andi_aluop: got %b, required 110", hist[2]); end
        run_instr(6'b001111, 6'b000000, 4, 16'h0000);
        checks++;
        if (hist[3] !== 3'b011) begin errors++; $display("FAIL lui_aluop: got %b, required 011", hist[3]); end
        run_instr(6'b001000, 6'b000000, 4, 16'h0000);
        checks++;
        if (hist[2] !== 3'b100) begin errors++; $display("FAIL addi_aluop: got %b, required 100", hist[2]); end
    endtask

    task automatic test_sw();
        run_instr(6'b101011, 6'b000000, 5, 16'h0008);
        checks += 2;
        if (s_mw !== 1'b1 || s_iord !== 1'b1) begin
            errors++; $display("FAIL sw_strobe: got mw=%b iord=%b, required 1/1", s_mw, s_iord);
        end
        if (n_rw !== 0) begin errors++; $display("FAIL sw_regwrite: got %0d, required 0", n_rw); end
    endtask

    task automatic test_illegal();
        logic [31:0] r0;
        r0 = retired;
        opcode = 6'b111111;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (illegal_op !== 1'b0 || IRWrite !== 1'b1) begin
            errors++; $display("FAIL ill_fetch: got ill=%b irw=%b, required 0/1", illegal_op, IRWrite);
        end
        @(posedge clk); #1;
        checks += 2;
        if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_pulse: got %b, required 1", illegal_op); end
        if (strobes !== 6'd0) begin errors++; $display("FAIL ill_strobes: got %b, required 000000", strobes); end
        @(posedge clk); #1;
        checks += 3;
        if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_drop: got %b, required 0", illegal_op); end
        if (MemRead !== 1'b1 || IorD !== 1'b0 || ALUSrcB !== 2'b01) begin
            errors++; $display("FAIL ill_back_to_fetch: got mr=%b iord=%b srcb=%b, required 1/0/01", MemRead, IorD, ALUSrcB);
        end
        if (retired !== r0) begin errors++; $display("FAIL ill_retired: got %0d, required %0d", retired, r0); end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b101011;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (MemWrite !== 1'b1) begin errors++; $display("FAIL memwr_hold: got %b, required 1", MemWrite); end
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (MemWrite !== 1'b0) begin errors++; $display("FAIL async_drop: got %b, required 0", MemWrite); end
        if (all_out !== 22'd0) begin errors++; $display("FAIL async_outputs: got %h, required 0", all_out); end
        if (retired !== 32'd0 || retired_4 !== 4'd0) begin
            errors++; $display("FAIL async_retired: got %0d/%0d, required 0/0", retired, retired_4);
        end
        exp_q.delete();
        exp_retired = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (all_out !== 22'd0) begin errors++; $display("FAIL post_reset_idle: got %h, required 0", all_out); end
        @(posedge clk); #1;
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b0) begin
            errors++; $display("FAIL post_reset_fetch: got mr=%b iord=%b, required 1/0", MemRead, IorD);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'b000000, 3, 16'h0000);
        checks += 3;
        if (s_pcsrc !== 2'b10 || s_pcw !== 1'b1) begin
            errors++; $display("FAIL j_pc: got pcsrc=%b pcw=%b, required 10/1", s_pcsrc, s_pcw);
        end
        if (retired !== 32'd17) begin errors++; $display("FAIL j_retired: got %0d, required 17", retired); end
        if (retired_4 !== 4'd1) begin errors++; $display("FAIL wrap4: got %0d, required 1", retired_4); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_jr_jal();
        test_itype();
        test_sw();
        test_illegal();
        test_reset_mid();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL pending_retires: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
